// File: rtl/sram_resp_pkg.sv
// Shared types, constants and helpers for the SRAM responder.
//   state_t     : responder FSM states
//   wr_hold_t   : write holding-register payload (address, data, byte strobes)
//   be_mask()   : 16-bit read mask from active-low byte enables
package sram_resp_pkg;

   localparam int unsigned DATA_W           = 16;
   localparam int unsigned BUS_ADDR_W       = 20;
   localparam int unsigned MAX_READ_LATENCY = 7;
   localparam int unsigned CNT_W            = $clog2(MAX_READ_LATENCY + 1);

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      RD_DRIVE,
      WR_ACTIVE
   } state_t;

   typedef struct packed {
      logic [BUS_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]     data;
      logic                  ub;
      logic                  lb;
   } wr_hold_t;

   // A byte reads through only when its active-low enable is asserted.
   function automatic logic [DATA_W-1:0] be_mask(input logic ub, input logic lb);
      return {{8{~ub}}, {8{~lb}}};
   endfunction

endpackage

// File: rtl/sram_array.sv
// Single-port word storage with per-byte write enables and asynchronous read.
//   clk   : write clock
//   we    : write strobe, be[1]=upper byte, be[0]=lower byte
//   addr  : shared read/write word address
//   wdata : write data, rdata : combinational read data
module sram_array
   import sram_resp_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [1:0]        be,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];

   // No reset: contents survive a system reset.
   always_ff @(posedge clk) begin
      if (we) begin
         if (be[0]) mem_q[addr][7:0]  <= wdata[7:0];
         if (be[1]) mem_q[addr][15:8] <= wdata[15:8];
      end
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/sram_responder.sv
// On-chip stand-in for the external 1Mx16 SRAM behind the SLC-3 controller.
//   Clk, Reset         : clock, async active-low reset
//   CE,UB,LB,OE,WE     : active-low SRAM strobes; ADDR word address
//   Data_in / Data_out : write data in, registered read data out
//   Data_oe            : registered, high while driving the shared bus
//   Init_we/addr/data  : preload port, honoured only when idle with CE high
//   Err                : one-cycle pulse on out-of-range access or rejected preload
module sram_responder
   import sram_resp_pkg::*;
#(
   parameter int unsigned ADDR_W       = 10,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  CE,
   input  logic                  UB,
   input  logic                  LB,
   input  logic                  OE,
   input  logic                  WE,
   input  logic [BUS_ADDR_W-1:0] ADDR,
   input  logic [DATA_W-1:0]     Data_in,
   output logic [DATA_W-1:0]     Data_out,
   output logic                  Data_oe,
   input  logic                  Init_we,
   input  logic [ADDR_W-1:0]     Init_addr,
   input  logic [DATA_W-1:0]     Init_data,
   output logic                  Err
);

   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(READ_LATENCY - 1);

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [BUS_ADDR_W-1:0] addr_q, addr_d;
   wr_hold_t              hold_q, hold_d;
   logic [DATA_W-1:0]     data_out_q, data_out_d;
   logic                  data_oe_q, data_oe_d;
   logic                  err_q, err_d;

   logic                  arr_we;
   logic [1:0]            arr_be;
   logic [ADDR_W-1:0]     arr_addr;
   logic [DATA_W-1:0]     arr_wdata;
   logic [DATA_W-1:0]     arr_rdata;
   logic [DATA_W-1:0]     rd_word;
   logic                  access;
   logic                  read_req;

   function automatic logic out_of_range(input logic [BUS_ADDR_W-1:0] a);
      return |(a >> ADDR_W);
   endfunction

   sram_array #(.ADDR_W(ADDR_W)) u_array (
      .clk   (Clk),
      .we    (arr_we),
      .be    (arr_be),
      .addr  (arr_addr),
      .wdata (arr_wdata),
      .rdata (arr_rdata)
   );

   // Port address depends only on state so the read path never loops through the write decision.
   always_comb begin
      arr_addr  = Init_addr;
      arr_wdata = Init_data;
      if (state_q == RD_WAIT || state_q == RD_DRIVE) begin
         arr_addr = addr_q[ADDR_W-1:0];
      end else if (state_q == WR_ACTIVE) begin
         arr_addr  = hold_q.addr[ADDR_W-1:0];
         arr_wdata = hold_q.data;
      end
   end

   assign access   = !CE && (!UB || !LB);
   assign read_req = access && !OE && WE;
   assign rd_word  = out_of_range(addr_q) ? '0 : (arr_rdata & be_mask(UB, LB));

   // Next-state, counter, holding registers, write strobes and outputs.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      hold_d     = hold_q;
      data_out_d = data_out_q;
      data_oe_d  = data_oe_q;
      err_d      = 1'b0;
      arr_we     = 1'b0;
      arr_be     = 2'b00;

      unique case (state_q)
         IDLE: begin
            data_oe_d = 1'b0;
            // WE wins when WE and OE are both low.
            if (access && !WE) begin
               state_d     = WR_ACTIVE;
               hold_d.addr = ADDR;
               hold_d.data = Data_in;
               hold_d.ub   = UB;
               hold_d.lb   = LB;
               err_d       = out_of_range(ADDR);
            end else if (access && !OE) begin
               state_d = RD_WAIT;
               addr_d  = ADDR;
               cnt_d   = LAT_LOAD;
               err_d   = out_of_range(ADDR);
            end
         end

         RD_WAIT: begin
            if (!read_req) begin
               state_d = IDLE;
            end else if (ADDR != addr_q) begin
               addr_d = ADDR;
               cnt_d  = LAT_LOAD;
            end else if (cnt_q == '0) begin
               state_d    = RD_DRIVE;
               data_oe_d  = 1'b1;
               data_out_d = rd_word;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         RD_DRIVE: begin
            if (!read_req) begin
               state_d   = IDLE;
               data_oe_d = 1'b0;
            end else if (ADDR != addr_q) begin
               state_d   = RD_WAIT;
               data_oe_d = 1'b0;
               addr_d    = ADDR;
               cnt_d     = LAT_LOAD;
            end else begin
               data_out_d = rd_word;
            end
         end

         WR_ACTIVE: begin
            data_oe_d = 1'b0;
            // Commit what was sampled on the last cycle WE and CE were both low.
            if (WE || CE) begin
               state_d = IDLE;
               arr_we  = !out_of_range(hold_q.addr);
               arr_be  = {~hold_q.ub, ~hold_q.lb};
            end else begin
               hold_d.addr = ADDR;
               hold_d.data = Data_in;
               hold_d.ub   = UB;
               hold_d.lb   = LB;
            end
         end

         default: state_d = IDLE;
      endcase

      // Preload shares the port; it is legal only when no access can be in flight.
      if (Init_we) begin
         if (state_q == IDLE && CE) begin
            arr_we = 1'b1;
            arr_be = 2'b11;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         hold_q     <= '0;
         data_out_q <= '0;
         data_oe_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         hold_q     <= hold_d;
         data_out_q <= data_out_d;
         data_oe_q  <= data_oe_d;
         err_q      <= err_d;
      end
   end

   assign Data_out = data_out_q;
   assign Data_oe  = data_oe_q;
   assign Err      = err_q;

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboarded bench for sram_responder: latency-2 instance for most scenarios,
// latency-3 instance sharing the same stimulus for the address-restart case.
module tb_sram_responder;

   logic        Clk, Reset;
   logic        CE, UB, LB, OE, WE;
   logic [19:0] ADDR;
   logic [15:0] Data_in;
   logic [15:0] Data_out, d3_out;
   logic        Data_oe, d3_oe;
   logic        Init_we;
   logic [9:0]  Init_addr;
   logic [15:0] Init_data;
   logic        Err, d3_err;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          err_cnt = 0;
   int          err3_cnt = 0;
   bit          oe_viol = 0;
   int          cyc;
   logic [15:0] exp;
   logic [15:0] model [1024];
   logic [15:0] exp_q [$];

   sram_responder #(.ADDR_W(10), .READ_LATENCY(2)) dut (
      .Clk(Clk), .Reset(Reset), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
      .ADDR(ADDR), .Data_in(Data_in), .Data_out(Data_out), .Data_oe(Data_oe),
      .Init_we(Init_we), .Init_addr(Init_addr), .Init_data(Init_data), .Err(Err)
   );

   sram_responder #(.ADDR_W(10), .READ_LATENCY(3)) dut3 (
      .Clk(Clk), .Reset(Reset), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
      .ADDR(ADDR), .Data_in(Data_in), .Data_out(d3_out), .Data_oe(d3_oe),
      .Init_we(Init_we), .Init_addr(Init_addr), .Init_data(Init_data), .Err(d3_err)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Observers sampled mid-cycle.
   always @(negedge Clk) begin
      if (Err === 1'b1) err_cnt++;
      if (d3_err === 1'b1) err3_cnt++;
      if (Data_oe === 1'b1 && WE === 1'b0) oe_viol = 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   function automatic logic [15:0] model_read(input logic [19:0] a, input logic ub, input logic lb);
      if (a[19:10] != 10'd0) return 16'h0000;
      return model[a[9:0]] & {{8{~ub}}, {8{~lb}}};
   endfunction

   function automatic logic [15:0] pop_exp();
      if (exp_q.size() == 0) return 16'hxxxx;
      return exp_q.pop_front();
   endfunction

   task automatic release_bus();
      CE = 1; OE = 1; WE = 1; UB = 1; LB = 1;
      @(posedge Clk); #1;
   endtask

   task automatic preload(input logic [9:0] a, input logic [15:0] d);
      Init_we = 1; Init_addr = a; Init_data = d;
      @(posedge Clk); #1;
      Init_we = 0;
      model[a] = d;
   endtask

   task automatic start_read(input logic [19:0] a, input logic ub, input logic lb);
      CE = 0; OE = 0; WE = 1; UB = ub; LB = lb; ADDR = a;
      exp_q.push_back(model_read(a, ub, lb));
   endtask

   task automatic do_write(input logic [19:0] a, input logic [15:0] d, input logic ub,
                           input logic lb, input logic oe_n);
      CE = 0; WE = 0; OE = oe_n; UB = ub; LB = lb; ADDR = a; Data_in = d;
      repeat (2) begin @(posedge Clk); #1; end
      CE = 1; WE = 1; OE = 1; UB = 1; LB = 1;
      @(posedge Clk); #1;
      if (a[19:10] == 10'd0) begin
         if (!ub) model[a[9:0]][15:8] = d[15:8];
         if (!lb) model[a[9:0]][7:0]  = d[7:0];
      end
   endtask

   // Edges from the sampling edge until Data_oe is seen high; -1 on timeout.
   task automatic wait_oe(input bit use3, output int cycles);
      cycles = -1;
      @(posedge Clk); #1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge Clk); #1;
         if ((use3 ? d3_oe : Data_oe) === 1'b1) begin
            cycles = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      Reset = 1; CE = 1; OE = 1; WE = 1; UB = 1; LB = 1; ADDR = '0; Data_in = '0;
      Init_we = 0; Init_addr = '0; Init_data = '0;
      #2 Reset = 0;
      repeat (3) @(posedge Clk);
      #1;
      n_tests++; if (Data_out !== 16'h0000) begin n_fail++; $display("FAIL reset_data_out: got %h want 0000", Data_out); end
      n_tests++; if (Data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_data_oe: got %b want 0", Data_oe); end
      n_tests++; if (Err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", Err); end
      n_tests++; if (d3_oe !== 1'b0) begin n_fail++; $display("FAIL reset_d3_oe: got %b want 0", d3_oe); end
      Reset = 1;
      @(posedge Clk); #1;
   endtask

   task automatic test_read_latency();
      preload(10'h003, 16'h1234);
      err_cnt = 0;
      start_read(20'h00003, 0, 0);
      wait_oe(0, cyc);
      n_tests++; if (cyc !== 2) begin n_fail++; $display("FAIL rd_latency: got %0d edges want 2", cyc); end
      exp = pop_exp();
      n_tests++; if (Data_out !== exp) begin n_fail++; $display("FAIL rd_data: got %h want %h", Data_out, exp); end
      n_tests++; if (Data_out !== 16'h1234) begin n_fail++; $display("FAIL rd_data_const: got %h want 1234", Data_out); end
      release_bus();
      n_tests++; if (Data_oe !== 1'b0) begin n_fail++; $display("FAIL rd_release_oe: got %b want 0", Data_oe); end
      n_tests++; if (err_cnt !== 0) begin n_fail++; $display("FAIL rd_no_err: got %0d pulses want 0", err_cnt); end
   endtask

   task automatic test_byte_write();
      preload(10'h010, 16'h1234);
      oe_viol = 0;
      do_write(20'h00010, 16'hABCD, 0, 1, 1);
      n_tests++; if (oe_viol !== 1'b0) begin n_fail++; $display("FAIL bw_oe_during_we: got %b want 0", oe_viol); end
      start_read(20'h00010, 0, 0);
      wait_oe(0, cyc);
      exp = pop_exp();
      n_tests++; if (Data_out !== exp || cyc !== 2) begin n_fail++; $display("FAIL bw_read: got %h after %0d want %h after 2", Data_out, cyc, exp); end
      n_tests++; if (Data_out !== 16'hAB34) begin n_fail++; $display("FAIL bw_read_const: got %h want AB34", Data_out); end
      release_bus();
      // Upper byte disabled on read must come back as zero.
      start_read(20'h00010, 1, 0);
      wait_oe(0, cyc);
      exp = pop_exp();
      n_tests++; if (Data_out !== exp) begin n_fail++; $display("FAIL bw_masked_read: got %h want %h", Data_out, exp); end
      release_bus();
   endtask

   task automatic test_we_priority();
      oe_viol = 0;
      do_write(20'h00005, 16'h00FF, 0, 0, 0);
      n_tests++; if (oe_viol !== 1'b0) begin n_fail++; $display("FAIL prio_oe_during_we: got %b want 0", oe_viol); end
      start_read(20'h00005, 0, 0);
      wait_oe(0, cyc);
      exp = pop_exp();
      n_tests++; if (Data_out !== exp || Data_out !== 16'h00FF) begin n_fail++; $display("FAIL prio_read: got %h want %h", Data_out, exp); end
      release_bus();
   endtask

   task automatic test_back_to_back();
      CE = 0; WE = 0; OE = 1; UB = 0; LB = 0; ADDR = 20'h00020; Data_in = 16'h4321;
      repeat (2) begin @(posedge Clk); #1; end
      // Release WE and request the read in the same cycle.
      WE = 1; OE = 0;
      model[10'h020] = 16'h4321;
      exp_q.push_back(model_read(20'h00020, 0, 0));
      @(posedge Clk); #1;
      wait_oe(0, cyc);
      exp = pop_exp();
      n_tests++; if (cyc !== 2) begin n_fail++; $display("FAIL b2b_latency: got %0d edges want 2", cyc); end
      n_tests++; if (Data_out !== exp) begin n_fail++; $display("FAIL b2b_data: got %h want %h", Data_out, exp); end
      release_bus();
   endtask

   task automatic test_out_of_range();
      preload(10'h000, 16'h5A5A);
      err_cnt = 0; err3_cnt = 0;
      start_read(20'h00400, 0, 0);
      wait_oe(0, cyc);
      exp = pop_exp();
      n_tests++; if (cyc !== 2) begin n_fail++; $display("FAIL oor_rd_latency: got %0d edges want 2", cyc); end
      n_tests++; if (Data_out !== exp || Data_out !== 16'h0000) begin n_fail++; $display("FAIL oor_rd_data: got %h want 0000", Data_out); end
      release_bus();
      n_tests++; if (err_cnt !== 1) begin n_fail++; $display("FAIL oor_rd_err: got %0d pulses want 1", err_cnt); end
      n_tests++; if (err3_cnt !== 1) begin n_fail++; $display("FAIL oor_rd_err3: got %0d pulses want 1", err3_cnt); end
      err_cnt = 0;
      do_write(20'h00400, 16'hFFFF, 0, 0, 1);
      n_tests++; if (err_cnt !== 1) begin n_fail++; $display("FAIL oor_wr_err: got %0d pulses want 1", err_cnt); end
      start_read(20'h00000, 0, 0);
      wait_oe(0, cyc);
      exp = pop_exp();
      n_tests++; if (Data_out !== exp || Data_out !== 16'h5A5A) begin n_fail++; $display("FAIL oor_wr_mem0: got %h want 5A5A", Data_out); end
      release_bus();
   endtask

   task automatic test_preload_reject();
      err_cnt = 0;
      CE = 0;
      Init_we = 1; Init_addr = 10'h010; Init_data = 16'h0000;
      @(posedge Clk); #1;
      Init_we = 0; CE = 1;
      @(posedge Clk); #1;
      n_tests++; if (err_cnt !== 1) begin n_fail++; $display("FAIL pre_reject_err: got %0d pulses want 1", err_cnt); end
      start_read(20'h00010, 0, 0);
      wait_oe(0, cyc);
      exp = pop_exp();
      n_tests++; if (Data_out !== exp) begin n_fail++; $display("FAIL pre_reject_mem: got %h want %h", Data_out, exp); end
      release_bus();
   endtask

   task automatic test_reset_mid_op();
      start_read(20'h00003, 0, 0);
      wait_oe(0, cyc);
      exp = pop_exp();
      n_tests++; if (Data_oe !== 1'b1 || Data_out !== exp) begin n_fail++; $display("FAIL rst_pre_read: got oe %b data %h want 1 %h", Data_oe, Data_out, exp); end
      #2 Reset = 0;
      #1;
      n_tests++; if (Data_oe !== 1'b0) begin n_fail++; $display("FAIL rst_async_oe: got %b want 0", Data_oe); end
      CE = 1; OE = 1; UB = 1; LB = 1;
      @(posedge Clk); #1;
      Reset = 1;
      @(posedge Clk); #1;
      n_tests++; if (Data_oe !== 1'b0 || Data_out !== 16'h0000) begin n_fail++; $display("FAIL rst_idle: got oe %b data %h want 0 0000", Data_oe, Data_out); end
      // Reset in the middle of a write: nothing may be committed.
      CE = 0; WE = 0; UB = 0; LB = 0; ADDR = 20'h00003; Data_in = 16'hFFFF;
      repeat (2) begin @(posedge Clk); #1; end
      Reset = 0;
      #2;
      CE = 1; WE = 1; UB = 1; LB = 1;
      @(posedge Clk); #1;
      Reset = 1;
      @(posedge Clk); #1;
      start_read(20'h00003, 0, 0);
      wait_oe(0, cyc);
      exp = pop_exp();
      n_tests++; if (Data_out !== exp || Data_out !== 16'h1234) begin n_fail++; $display("FAIL rst_contents: got %h want 1234", Data_out); end
      release_bus();
   endtask

   task automatic test_addr_change();
      preload(10'h001, 16'h1111);
      preload(10'h002, 16'h2222);
      CE = 0; OE = 0; WE = 1; UB = 0; LB = 0; ADDR = 20'h00001;
      @(posedge Clk); #1;
      n_tests++; if (d3_oe !== 1'b0) begin n_fail++; $display("FAIL ac_early_oe: got %b want 0", d3_oe); end
      ADDR = 20'h00002;
      wait_oe(1, cyc);
      n_tests++; if (cyc !== 3) begin n_fail++; $display("FAIL ac_latency: got %0d edges want 3", cyc); end
      exp = model_read(20'h00002, 0, 0);
      n_tests++; if (d3_out !== exp) begin n_fail++; $display("FAIL ac_data: got %h want %h", d3_out, exp); end
      release_bus();
   endtask

   initial begin
      test_reset();
      test_read_latency();
      test_byte_write();
      test_we_priority();
      test_back_to_back();
      test_out_of_range();
      test_preload_reject();
      test_reset_mid_op();
      test_addr_change();
      n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_empty: got %0d left want 0", exp_q.size()); end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_responder.md
# sram_responder

Synthesizable responder for the SLC-3 external SRAM interface. It answers the CPU-side active-low strobes (CE, UB, LB, OE, WE) and 20-bit ADDR with on-chip byte-enabled storage. It sits where the physical 1Mx16 chip and tristate buffer sit, so the processor can run on-chip in simulation and on boards without the SRAM. Read latency is programmable, writes commit on WE deassertion, and a preload port fills memory before Run.

## Interface
- ADDR_W, 10: implemented word-address bits (depth 2^ADDR_W words).
- READ_LATENCY, 1: cycles from a sampled read strobe to valid Data_out; legal range 1..7.
- Clk  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- CE, UB, LB, OE, WE  in  1 each  active-low chip enable, upper/lower byte enables, output enable, write enable.
- ADDR  in  20  word address; bits [19:ADDR_W] must be zero.
- Data_in  in  16  write data from the controller (Data_to_SRAM).
- Data_out  out  16  read data (Data_from_SRAM).
- Data_oe  out  1  high while this block drives the shared Data bus.
- Init_we  in  1  preload strobe, active-high.
- Init_addr  in  ADDR_W  preload word address.
- Init_data  in  16  preload word (both bytes written).
- Err  out  1  one-cycle pulse on an out-of-range access or a rejected preload.

## Operation
- States: IDLE, RD_WAIT, RD_DRIVE, WR_ACTIVE.
- An access is active when CE=0 and (UB=0 or LB=0).
- IDLE to WR_ACTIVE: an active access with WE=0. WE has priority over OE when both are low.
- IDLE to RD_WAIT: an active access with OE=0 and WE=1. The address is latched and the latency counter loads READ_LATENCY-1.
- RD_WAIT:
  - Counter decrements each cycle. At 0, the state moves to RD_DRIVE.
  - An ADDR change restarts the counter and relatches the address.
  - Strobe release returns the state to IDLE.
- RD_DRIVE:
  - Data_oe=1 and Data_out = mem[addr], masked: any byte whose UB/LB is high reads as 0x00.
  - An ADDR change returns the state to RD_WAIT and restarts latency.
  - Release of OE or CE returns the state to IDLE, and Data_oe falls in the same cycle.
- WR_ACTIVE:
  - Each cycle samples ADDR, Data_in, UB and LB into holding registers. Data_oe=0.
  - When WE or CE deasserts, the last sampled values commit to memory using per-byte enables, then the state returns to IDLE.
- Out of range (ADDR[19:ADDR_W] ≠ 0):
  - A read returns 16'h0000 with normal latency.
  - A write is discarded.
  - Err pulses once, on entry to the access.
- Preload:
  - Honored only in IDLE with CE=1. It writes Init_data to Init_addr on that edge.
  - Otherwise it is ignored and Err pulses.
- Memory contents are not cleared by Reset.

## Timing
- Reset values: state IDLE, Data_out=16'h0000, Data_oe=0, Err=0, counter=0, holding registers=0.
- Reset asserted mid-operation forces IDLE immediately (asynchronously) and drops Data_oe. A write in progress is discarded.
- Read latency: strobe sampled at edge k gives Data_oe=1 and valid Data_out after edge k+READ_LATENCY.
- Write: data is visible to a read started at the edge after the commit edge. Back-to-back write then read is legal with no idle cycle.
- Data_oe is registered and glitch-free. It never rises in a cycle where WE is low.
- Err is registered: it is high for the single cycle after the triggering edge.

## Structure
- Package sram_resp_pkg:
  - state_t enum (IDLE, RD_WAIT, RD_DRIVE, WR_ACTIVE).
  - Constant MAX_READ_LATENCY = 7.
  - Function be_mask(ub, lb) returning the 16-bit byte mask.
- Sub-module sram_array: single-port, 2^ADDR_W x 16, per-byte write enables, asynchronous read. It is the only storage.
- The top contains the FSM, latency counter, holding registers, out-of-range check and preload arbitration.

## Test plan
- Preload 0x003=16'h1234, READ_LATENCY=2, assert CE/OE/UB/LB low with ADDR=3 at edge 0 -> Data_oe=1 and Data_out=16'h1234 after edge 2, not before.
- Preload 0x010=16'h1234. Write 16'hABCD to 0x010 with UB=0, LB=1, then release WE -> a subsequent read returns 16'hAB34.
- OE and WE both low, ADDR=5, Data_in=16'h00FF, then release WE -> Data_oe stays 0 throughout and a read of 5 returns 16'h00FF.
- ADDR=20'h00400 with ADDR_W=10:
  - Read returns 16'h0000 and Err pulses once.
  - Write of 16'hFFFF leaves mem[0] unchanged.
- Reset low during RD_DRIVE -> Data_oe=0 in the same cycle and state is IDLE. After release, the previous contents read back unchanged.
- ADDR changes from 1 to 2 in RD_WAIT (READ_LATENCY=3) -> Data_oe rises 3 cycles after the change, with mem[2] on Data_out.
